// File: rtl/axi_pkg.sv
// Single-beat AXI4 channel payload types shared by client and server sides.
// Address/data/id widths are fixed here; channel structs carry no handshakes.
package axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } aw_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        resp_t           resp;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        resp_t             resp;
        logic              last;
    } r_chan_t;

endpackage

// File: rtl/multisim_axi_pkg.sv
// Transport packets and client FSM states shared by multisim client/server.
// Packets wrap the axi_pkg channel payloads for one single-beat transaction.
package multisim_axi_pkg;

    import axi_pkg::*;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } client_state_e;

    typedef struct packed {
        logic     is_write;
        aw_chan_t aw;
        w_chan_t  w;
        ar_chan_t ar;
    } req_pkt_t;

    typedef struct packed {
        logic    is_write;
        b_chan_t b;
        r_chan_t r;
        logic    timeout;
    } rsp_pkt_t;

endpackage

// File: rtl/multisim_client_axi_master.sv
// Replays transport requests as single-beat AXI master transactions, one at a time.
// Ports: clk/rst_n, req/rsp valid-ready transport, AXI AW/W/B/AR/R master, o_txn_count.
module multisim_client_axi_master
    import multisim_axi_pkg::*;
#(
    parameter type axi_aw_t = axi_pkg::aw_chan_t,
    parameter type axi_w_t  = axi_pkg::w_chan_t,
    parameter type axi_b_t  = axi_pkg::b_chan_t,
    parameter type axi_ar_t = axi_pkg::ar_chan_t,
    parameter type axi_r_t  = axi_pkg::r_chan_t,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  req_pkt_t    i_req,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output rsp_pkt_t    o_rsp,
    output axi_aw_t     o_axi_m_aw,
    output logic        o_axi_m_awvalid,
    input  logic        i_axi_m_awready,
    output axi_w_t      o_axi_m_w,
    output logic        o_axi_m_wvalid,
    input  logic        i_axi_m_wready,
    input  axi_b_t      i_axi_m_b,
    input  logic        i_axi_m_bvalid,
    output logic        o_axi_m_bready,
    output axi_ar_t     o_axi_m_ar,
    output logic        o_axi_m_arvalid,
    input  logic        i_axi_m_arready,
    input  axi_r_t      i_axi_m_r,
    input  logic        i_axi_m_rvalid,
    output logic        o_axi_m_rready,
    output logic [31:0] o_txn_count
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    client_state_e state_q;
    req_pkt_t      req_q;
    rsp_pkt_t      rsp_q;
    logic          awvalid_q;
    logic          wvalid_q;
    logic          bready_q;
    logic          arvalid_q;
    logic          rready_q;
    logic          rsp_valid_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   txn_q;

    logic aw_left;
    logic w_left;
    logic timed_out;

    // A channel is still pending if its valid is up and the slave is not taking it.
    assign aw_left   = awvalid_q & ~i_axi_m_awready;
    assign w_left    = wvalid_q & ~i_axi_m_wready;
    assign timed_out = (cnt_q == LIMIT);

    // Gated by rst_n so ready is low during reset yet high right after release.
    assign o_req_ready     = rst_n & (state_q == IDLE);
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp           = rsp_q;
    assign o_axi_m_aw      = req_q.aw;
    assign o_axi_m_awvalid = awvalid_q;
    assign o_axi_m_w       = req_q.w;
    assign o_axi_m_wvalid  = wvalid_q;
    assign o_axi_m_bready  = bready_q;
    assign o_axi_m_ar      = req_q.ar;
    assign o_axi_m_arvalid = arvalid_q;
    assign o_axi_m_rready  = rready_q;
    assign o_txn_count     = txn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
            txn_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        req_q <= i_req;
                        cnt_q <= '0;
                        if (i_req.is_write) begin
                            state_q   <= WR_ADDR_DATA;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (!aw_left && !w_left) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= WR_RESP;
                    end else if (timed_out) begin
                        awvalid_q   <= 1'b0;
                        wvalid_q    <= 1'b0;
                        rsp_q       <= '{is_write: 1'b1, b: '0, r: '0, timeout: 1'b1};
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= RSP;
                    end else begin
                        awvalid_q <= aw_left;
                        wvalid_q  <= w_left;
                        cnt_q     <= cnt_q + CW'(1);
                    end
                end
                WR_RESP: begin
                    if (i_axi_m_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_q       <= '{is_write: 1'b1, b: i_axi_m_b, r: '0, timeout: 1'b0};
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= RSP;
                    end else if (timed_out) begin
                        bready_q    <= 1'b0;
                        rsp_q       <= '{is_write: 1'b1, b: '0, r: '0, timeout: 1'b1};
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RD_ADDR: begin
                    if (i_axi_m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= RD_DATA;
                    end else if (timed_out) begin
                        arvalid_q   <= 1'b0;
                        rsp_q       <= '{is_write: 1'b0, b: '0, r: '0, timeout: 1'b1};
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RD_DATA: begin
                    if (i_axi_m_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_q       <= '{is_write: 1'b0, b: '0, r: i_axi_m_r, timeout: 1'b0};
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= RSP;
                    end else if (timed_out) begin
                        rready_q    <= 1'b0;
                        rsp_q       <= '{is_write: 1'b0, b: '0, r: '0, timeout: 1'b1};
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RSP: begin
                    // Transport backpressure is unbounded, so no wait count here.
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        txn_q       <= txn_q + 32'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multisim_client_axi_master.sv
// Self-checking bench for multisim_client_axi_master with a scripted AXI slave.
// Expected responses are queued at request time and checked on the rsp handshake.
module tb_multisim_client_axi_master;

    import axi_pkg::*;
    import multisim_axi_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    req_pkt_t    i_req = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    rsp_pkt_t    o_rsp;
    aw_chan_t    o_axi_m_aw;
    logic        o_axi_m_awvalid;
    logic        i_axi_m_awready = 1'b0;
    w_chan_t     o_axi_m_w;
    logic        o_axi_m_wvalid;
    logic        i_axi_m_wready = 1'b0;
    b_chan_t     i_axi_m_b = '0;
    logic        i_axi_m_bvalid = 1'b0;
    logic        o_axi_m_bready;
    ar_chan_t    o_axi_m_ar;
    logic        o_axi_m_arvalid;
    logic        i_axi_m_arready = 1'b0;
    r_chan_t     i_axi_m_r = '0;
    logic        i_axi_m_rvalid = 1'b0;
    logic        o_axi_m_rready;
    logic [31:0] o_txn_count;

    always #5 clk = ~clk;

    multisim_client_axi_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req           (i_req),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp           (o_rsp),
        .o_axi_m_aw      (o_axi_m_aw),
        .o_axi_m_awvalid (o_axi_m_awvalid),
        .i_axi_m_awready (i_axi_m_awready),
        .o_axi_m_w       (o_axi_m_w),
        .o_axi_m_wvalid  (o_axi_m_wvalid),
        .i_axi_m_wready  (i_axi_m_wready),
        .i_axi_m_b       (i_axi_m_b),
        .i_axi_m_bvalid  (i_axi_m_bvalid),
        .o_axi_m_bready  (o_axi_m_bready),
        .o_axi_m_ar      (o_axi_m_ar),
        .o_axi_m_arvalid (o_axi_m_arvalid),
        .i_axi_m_arready (i_axi_m_arready),
        .i_axi_m_r       (i_axi_m_r),
        .i_axi_m_rvalid  (i_axi_m_rvalid),
        .o_axi_m_rready  (o_axi_m_rready),
        .o_txn_count     (o_txn_count)
    );

    int checks = 0;
    int failures = 0;
    int unsigned exp_txn = 0;
    rsp_pkt_t exp_q[$];

    // Slave script: ready/valid rises in the Nth cycle of waiting (ar_lat 0 = never).
    int aw_lat = 1, w_lat = 1, b_lat = 1, ar_lat = 1, r_lat = 1;
    int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
    b_chan_t slv_b = '0;
    r_chan_t slv_r = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0;
            i_axi_m_awready <= 1'b0;
            i_axi_m_wready  <= 1'b0;
            i_axi_m_bvalid  <= 1'b0;
            i_axi_m_arready <= 1'b0;
            i_axi_m_rvalid  <= 1'b0;
        end else begin
            aw_c <= o_axi_m_awvalid ? aw_c + 1 : 0;
            w_c  <= o_axi_m_wvalid ? w_c + 1 : 0;
            b_c  <= o_axi_m_bready ? b_c + 1 : 0;
            ar_c <= o_axi_m_arvalid ? ar_c + 1 : 0;
            r_c  <= o_axi_m_rready ? r_c + 1 : 0;
            i_axi_m_awready <= o_axi_m_awvalid && (aw_c + 1 >= aw_lat);
            i_axi_m_wready  <= o_axi_m_wvalid && (w_c + 1 >= w_lat);
            i_axi_m_bvalid  <= o_axi_m_bready && (b_c + 1 >= b_lat);
            i_axi_m_arready <= o_axi_m_arvalid && (ar_lat > 0) && (ar_c + 1 >= ar_lat);
            i_axi_m_rvalid  <= o_axi_m_rready && (r_c + 1 >= r_lat);
            i_axi_m_b <= slv_b;
            i_axi_m_r <= slv_r;
        end
    end

    // Monotonic event counters; tests compare deltas.
    int aw_hs = 0, w_hs = 0, ar_hs = 0, aw_seen = 0, ar_cyc = 0, rsp_seen = 0;
    logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;

    always @(posedge clk) begin
        if (o_axi_m_awvalid && i_axi_m_awready) begin
            aw_hs   <= aw_hs + 1;
            aw_addr <= o_axi_m_aw.addr;
        end
        if (o_axi_m_wvalid && i_axi_m_wready) begin
            w_hs   <= w_hs + 1;
            w_data <= o_axi_m_w.data;
        end
        if (o_axi_m_arvalid && i_axi_m_arready) begin
            ar_hs   <= ar_hs + 1;
            ar_addr <= o_axi_m_ar.addr;
        end
        if (o_axi_m_awvalid) aw_seen <= aw_seen + 1;
        if (o_axi_m_arvalid) ar_cyc <= ar_cyc + 1;
        if (o_rsp_valid) rsp_seen <= rsp_seen + 1;
    end

    function automatic req_pkt_t mk_wr(input logic [31:0] a, input logic [31:0] d);
        req_pkt_t r;
        r = '0;
        r.is_write = 1'b1;
        r.aw.addr = a;
        r.aw.size = 3'd2;
        r.aw.burst = 2'b01;
        r.w.data = d;
        r.w.strb = 4'hF;
        r.w.last = 1'b1;
        return r;
    endfunction

    function automatic req_pkt_t mk_rd(input logic [31:0] a);
        req_pkt_t r;
        r = '0;
        r.ar.addr = a;
        r.ar.size = 3'd2;
        r.ar.burst = 2'b01;
        return r;
    endfunction

    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic send_req(input req_pkt_t r, output bit ok);
        ok = 1'b0;
        i_req = r;
        i_req_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (o_req_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    // Raises rsp ready, returns on the negedge after the rsp handshake.
    task automatic wait_rsp(output rsp_pkt_t obs, output bit ok);
        ok = 1'b0;
        obs = '0;
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (o_rsp_valid) begin
                obs = o_rsp;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b0 || o_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, need 0 0", o_req_ready, o_rsp_valid);
        end
        checks++;
        if ({o_axi_m_awvalid, o_axi_m_wvalid, o_axi_m_bready, o_axi_m_arvalid, o_axi_m_rready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_axi: aw w b ar r = %b%b%b%b%b, need 00000", o_axi_m_awvalid,
                     o_axi_m_wvalid, o_axi_m_bready, o_axi_m_arvalid, o_axi_m_rready);
        end
        checks++;
        if (o_txn_count !== 32'd0 || o_rsp !== '0) begin
            failures++;
            $display("FAIL reset_state: txn=%0d rsp=%h, need 0 0", o_txn_count, o_rsp);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b need 1", o_req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_write;
        rsp_pkt_t obs, exp;
        bit ok;
        int aw0, w0;
        aw0 = aw_hs; w0 = w_hs;
        aw_lat = 2; w_lat = 4; b_lat = 1;
        slv_b = '{id: 4'h0, resp: RESP_OKAY};
        exp = '0;
        exp.is_write = 1'b1;
        exp.b = slv_b;
        exp_q.push_back(exp);
        send_req(mk_wr(32'h1000, 32'hDEADBEEF), ok);
        checks++;
        if (!ok || o_axi_m_awvalid !== 1'b1 || o_axi_m_wvalid !== 1'b1) begin
            failures++;
            $display("FAIL wr_latency: ok=%b awvalid=%b wvalid=%b, need 1 1 1", ok, o_axi_m_awvalid, o_axi_m_wvalid);
        end
        wait_rsp(obs, ok);
        exp = exp_q.pop_front();
        if (ok) exp_txn++;
        checks++;
        if (!ok || obs !== exp) begin
            failures++;
            $display("FAIL wr_rsp: ok=%b got %h need %h", ok, obs, exp);
        end
        checks++;
        if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || aw_addr !== 32'h1000 || w_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_beats: aw=%0d w=%0d addr=%h data=%h, need 1 1 1000 deadbeef",
                     aw_hs - aw0, w_hs - w0, aw_addr, w_data);
        end
        checks++;
        if (o_txn_count !== exp_txn) begin
            failures++;
            $display("FAIL wr_count: got %0d need %0d", o_txn_count, exp_txn);
        end
    endtask

    task automatic test_read;
        rsp_pkt_t obs, exp;
        bit ok;
        int seen0;
        seen0 = aw_seen;
        ar_lat = 1; r_lat = 3;
        slv_r = '{id: 4'h0, data: 32'hCAFEF00D, resp: RESP_OKAY, last: 1'b1};
        exp = '0;
        exp.r = slv_r;
        exp_q.push_back(exp);
        send_req(mk_rd(32'h2000), ok);
        checks++;
        if (!ok || o_axi_m_arvalid !== 1'b1) begin
            failures++;
            $display("FAIL rd_latency: ok=%b arvalid=%b, need 1 1", ok, o_axi_m_arvalid);
        end
        wait_rsp(obs, ok);
        exp = exp_q.pop_front();
        if (ok) exp_txn++;
        checks++;
        if (!ok || obs !== exp) begin
            failures++;
            $display("FAIL rd_rsp: ok=%b got %h need %h", ok, obs, exp);
        end
        checks++;
        if (aw_seen != seen0 || ar_addr !== 32'h2000 || o_txn_count !== exp_txn) begin
            failures++;
            $display("FAIL rd_side: awvalid_cycles=%0d addr=%h txn=%0d, need 0 2000 %0d",
                     aw_seen - seen0, ar_addr, o_txn_count, exp_txn);
        end
    endtask

    task automatic test_simultaneous;
        rsp_pkt_t obs, exp;
        bit ok;
        int aw0, w0;
        aw0 = aw_hs; w0 = w_hs;
        aw_lat = 1; w_lat = 1; b_lat = 2;
        slv_b = '{id: 4'h5, resp: RESP_SLVERR};
        exp = '0;
        exp.is_write = 1'b1;
        exp.b = slv_b;
        exp_q.push_back(exp);
        send_req(mk_wr(32'h3000, 32'h12345678), ok);
        @(negedge clk);
        checks++;
        if (!ok || o_axi_m_bready !== 1'b1 || o_axi_m_awvalid !== 1'b0 || o_axi_m_wvalid !== 1'b0) begin
            failures++;
            $display("FAIL sim_wr_resp_entry: ok=%b bready=%b aw=%b w=%b, need 1 1 0 0", ok,
                     o_axi_m_bready, o_axi_m_awvalid, o_axi_m_wvalid);
        end
        wait_rsp(obs, ok);
        exp = exp_q.pop_front();
        if (ok) exp_txn++;
        checks++;
        if (!ok || obs !== exp || aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
            failures++;
            $display("FAIL sim_rsp: ok=%b got %h aw=%0d w=%0d, need %h 1 1", ok, obs,
                     aw_hs - aw0, w_hs - w0, exp);
        end
    endtask

    task automatic test_timeout;
        rsp_pkt_t obs, exp;
        bit ok;
        int c0;
        c0 = ar_cyc;
        ar_lat = 0;
        exp = '0;
        exp.timeout = 1'b1;
        exp_q.push_back(exp);
        send_req(mk_rd(32'h4000), ok);
        wait_rsp(obs, ok);
        exp = exp_q.pop_front();
        if (ok) exp_txn++;
        checks++;
        if (!ok || obs !== exp) begin
            failures++;
            $display("FAIL to_rsp: ok=%b got %h need %h", ok, obs, exp);
        end
        checks++;
        if (ar_cyc - c0 != TO || o_axi_m_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL to_arvalid: cycles=%0d arvalid=%b, need %0d 0", ar_cyc - c0, o_axi_m_arvalid, TO);
        end
        ar_lat = 1; r_lat = 1;
        slv_r = '{id: 4'h2, data: 32'h0BADF00D, resp: RESP_OKAY, last: 1'b1};
        exp = '0;
        exp.r = slv_r;
        exp_q.push_back(exp);
        send_req(mk_rd(32'h4004), ok);
        wait_rsp(obs, ok);
        exp = exp_q.pop_front();
        if (ok) exp_txn++;
        checks++;
        if (!ok || obs !== exp || o_txn_count !== exp_txn) begin
            failures++;
            $display("FAIL to_recover: ok=%b got %h txn=%0d need %h %0d", ok, obs, o_txn_count, exp, exp_txn);
        end
    endtask

    task automatic test_backpressure;
        rsp_pkt_t obs, exp, snap;
        bit ok, bad, up;
        aw_lat = 1; w_lat = 2; b_lat = 1;
        slv_b = '{id: 4'h1, resp: RESP_OKAY};
        exp = '0;
        exp.is_write = 1'b1;
        exp.b = slv_b;
        exp_q.push_back(exp);
        send_req(mk_wr(32'h5000, 32'hA5A5A5A5), ok);
        up = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (o_rsp_valid) begin
                up = 1'b1;
                break;
            end
            @(negedge clk);
        end
        snap = o_rsp;
        bad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (o_rsp !== snap || o_rsp_valid !== 1'b1 || o_req_ready !== 1'b0 || o_txn_count !== exp_txn)
                bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!up || bad) begin
            failures++;
            $display("FAIL bp_stable: rsp_up=%b unstable=%b, need 1 0", up, bad);
        end
        wait_rsp(obs, ok);
        exp = exp_q.pop_front();
        if (ok) exp_txn++;
        checks++;
        if (!ok || obs !== exp || o_txn_count !== exp_txn) begin
            failures++;
            $display("FAIL bp_rsp: ok=%b got %h txn=%0d need %h %0d", ok, obs, o_txn_count, exp, exp_txn);
        end
    endtask

    task automatic test_reset_mid;
        rsp_pkt_t obs, exp;
        bit ok, hit;
        int seen0;
        ar_lat = 1; r_lat = 10;
        slv_r = '{id: 4'h0, data: 32'h11111111, resp: RESP_OKAY, last: 1'b1};
        exp = '0;
        exp.r = slv_r;
        exp_q.push_back(exp);
        send_req(mk_rd(32'h6000), ok);
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_axi_m_rready) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        seen0 = rsp_seen;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_txn = 0;
        checks++;
        if (!hit || o_axi_m_rready !== 1'b0 || o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0 ||
            o_txn_count !== 32'd0 || o_rsp !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: in_rd_data=%b rready=%b rsp_valid=%b req_ready=%b txn=%0d, need 1 0 0 0 0",
                     hit, o_axi_m_rready, o_rsp_valid, o_req_ready, o_txn_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_ready: got %b need 1", o_req_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rsp_seen != seen0) begin
            failures++;
            $display("FAIL rst_mid_no_rsp: rsp_valid cycles=%0d need 0", rsp_seen - seen0);
        end
        r_lat = 2;
        slv_r = '{id: 4'h3, data: 32'h22222222, resp: RESP_OKAY, last: 1'b1};
        exp = '0;
        exp.r = slv_r;
        exp_q.push_back(exp);
        send_req(mk_rd(32'h6004), ok);
        wait_rsp(obs, ok);
        exp = exp_q.pop_front();
        if (ok) exp_txn++;
        checks++;
        if (!ok || obs !== exp || o_txn_count !== exp_txn) begin
            failures++;
            $display("FAIL rst_mid_next: ok=%b got %h txn=%0d need %h %0d", ok, obs, o_txn_count, exp, exp_txn);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_simultaneous();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multisim_client_axi_master.md
MULTISIM_CLIENT_AXI_MASTER -- requirements
Module: multisim_client_axi_master

Interface
REQ-001 SHALL have type parameters axi_aw_t, axi_w_t, axi_b_t, axi_ar_t, axi_r_t, default from axi_pkg, meaning the per-channel AXI payload structs.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum wait for any AXI handshake before error.
REQ-003 SHALL have these ports (one clock; reset asynchronous, active-low):
  clk  in  1  sole clock
  rst_n  in  1  asynchronous active-low reset
  i_req_valid  in  1  transport request valid
  o_req_ready  out  1  transport request ready
  i_req  in  req_pkt_t  {is_write, aw, w, ar}
  o_rsp_valid  out  1  transport response valid
  i_rsp_ready  in  1  transport response ready
  o_rsp  out  rsp_pkt_t  {is_write, b, r, timeout}
  o_axi_m_aw, o_axi_m_awvalid, i_axi_m_awready  AW channel, master side
  o_axi_m_w, o_axi_m_wvalid, i_axi_m_wready  W channel
  i_axi_m_b, i_axi_m_bvalid, o_axi_m_bready  B channel
  o_axi_m_ar, o_axi_m_arvalid, i_axi_m_arready  AR channel
  i_axi_m_r, i_axi_m_rvalid, o_axi_m_rready  R channel
  o_txn_count  out  32  completed transactions, wraps

Function
REQ-004 SHALL replay single-beat transactions received from a multisim server as an AXI master, one transaction outstanding.
REQ-005 SHALL implement states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-006 IDLE: o_req_ready=1; on i_req_valid&&o_req_ready SHALL capture i_req and go to WR_ADDR_DATA if is_write, else RD_ADDR.
REQ-007 WR_ADDR_DATA: SHALL assert awvalid and wvalid together from the next cycle; each SHALL deassert independently after its own handshake; go to WR_RESP when both are done, in either order or in the same cycle.
REQ-008 WR_RESP: bready=1; on bvalid SHALL capture i_axi_m_b and go to RSP.
REQ-009 RD_ADDR: arvalid=1 until arready, then RD_DATA; RD_DATA: rready=1; on rvalid SHALL capture i_axi_m_r and go to RSP.
REQ-010 Payloads and valids on AW/W/AR SHALL stay stable while valid and not ready.
REQ-011 RSP: o_rsp_valid=1 with o_rsp stable until i_rsp_ready; on handshake SHALL increment o_txn_count (wrap 2^32-1 -> 0) and return to IDLE.
REQ-012 o_req_ready SHALL be 0 in all states except IDLE; a request is never accepted while a response is pending.
REQ-013 A wait counter SHALL reset on each state entry and count cycles in WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA; on reaching TIMEOUT_CYCLES SHALL drop all AXI valids/readies, go to RSP with timeout=1 and b/r fields zero.
REQ-014 The counter SHALL not run in RSP (transport backpressure is unbounded).
REQ-015 Latency: request accept to first awvalid/arvalid SHALL be exactly 1 cycle; response capture to o_rsp_valid SHALL be exactly 1 cycle.

Reset
REQ-016 While rst_n=0: state IDLE, all AXI valids/readies 0, o_rsp_valid 0, o_req_ready 0, o_rsp zero, o_txn_count 0, wait counter 0.
REQ-017 Reset mid-transaction SHALL abandon it silently; no response issued; o_req_ready SHALL be 1 the first cycle after deassertion.

Structure
REQ-018 req_pkt_t, rsp_pkt_t and the state enum SHALL live in shared package multisim_axi_pkg, built on axi_pkg channel types, for reuse by the server side.
REQ-019 SHALL be one module, no sub-modules; counters are inline.

Verification
REQ-020 Write: req is_write=1, addr 0x1000, data 0xDEADBEEF; slave awready at cycle 2, wready at cycle 4, bvalid OKAY -> one AW, one W, rsp is_write=1 b=OKAY timeout=0, o_txn_count=1.
REQ-021 Read: req addr 0x2000; slave returns r.data 0xCAFEF00D after 3 cycles -> rsp r.data=0xCAFEF00D, awvalid never asserted.
REQ-022 Simultaneous: awready and wready both high in the first valid cycle -> WR_RESP entered next cycle, no duplicate beats.
REQ-023 Timeout: TIMEOUT_CYCLES=16, slave never raises arready -> arvalid drops after 16 cycles, rsp timeout=1, then new request accepted.
REQ-024 Backpressure: i_rsp_ready held low 50 cycles -> o_rsp stable, no timeout, o_req_ready=0 throughout, count increments once.
REQ-025 Reset mid-read (during RD_DATA) -> all outputs to reset values, no o_rsp_valid, next request processed normally.
